// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command engine:
// opcodes, reply bytes, response lengths and the FSM state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_START = 8'h53;
  localparam logic [7:0] OP_DUMP  = 8'h44;

  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;

  localparam logic [2:0] LEN_ACK  = 3'd1;
  localparam logic [2:0] LEN_READ = 3'd2;
  localparam logic [2:0] LEN_DUMP = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    ARGS,
    MEM,
    RESP,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Number of argument bytes that follow an opcode; 0 means execute immediately.
  function automatic logic [2:0] args_needed(input logic [7:0] op);
    if (op == OP_WRITE) return 3'd4;
    if (op == OP_READ)  return 3'd2;
    return 3'd0;
  endfunction

endpackage

// File: rtl/uart_resp_shifter.sv
// Response buffer (up to 6 bytes, MSB-first) and the valid/busy handshake
// toward the UART transmitter. Pulses done after the last byte has shifted out.
module uart_resp_shifter
  import uart_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [2:0]  len,
  input  logic [47:0] resp_data,
  output logic        txValid,
  output logic [7:0]  txData,
  input  logic        txBusy,
  output logic        done
);

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [2:0]  len_reg;
  logic [47:0] buf_reg;
  logic [7:0]  byte_arr [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bytes
      if (gi < 6) begin : g_used
        assign byte_arr[gi] = buf_reg[47 - 8*gi -: 8];
      end else begin : g_pad
        assign byte_arr[gi] = 8'h00;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
      len_reg   <= 3'd0;
      buf_reg   <= 48'h0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (load && state_reg == IDLE) begin
        len_reg <= len;
        buf_reg <= resp_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = RESP;
          idx_next   = 3'd0;
        end
      end
      RESP: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (txBusy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Entered only after busy was seen high, so low here is the falling edge.
        if (!txBusy) begin
          if (idx_reg == len_reg - 3'd1) begin
            state_next = IDLE;
            done       = 1'b1;
          end else begin
            state_next = RESP;
            idx_next   = idx_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign txValid = (state_reg == RESP) || (state_reg == WAIT_BUSY);
  assign txData  = txValid ? byte_arr[idx_reg] : 8'h00;

endmodule

// File: rtl/uart_cmd_engine.sv
// Byte-serial host command decoder: assembles W/R/S/D frames from the UART
// receiver, drives the override memory port and queues reply bytes for TX.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2700000,
  parameter int MEM_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxValid,
  input  logic [7:0]  rxData,
  output logic        txValid,
  output logic [7:0]  txData,
  input  logic        txBusy,
  output logic        memControl,
  output logic        memRnW,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  input  logic [15:0] memDataOut,
  output logic        start,
  input  logic [15:0] dbgPc,
  input  logic [15:0] dbgAcc,
  input  logic [15:0] dbgIr,
  output logic        rxOverrun
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    MEM_LAST = 3'(MEM_LATENCY);

  state_t        state_reg, state_next;
  logic [7:0]    op_reg, op_next;
  logic [31:0]   arg_buf_reg, arg_buf_next;
  logic [2:0]    arg_cnt_reg, arg_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [2:0]    mem_cnt_reg, mem_cnt_next;
  logic [15:0]   rd_data_reg, rd_data_next;
  logic          start_reg, start_next;
  logic          overrun_reg, overrun_next;
  logic          loaded_reg, loaded_next;

  logic          shift_load;
  logic [2:0]    shift_len;
  logic [47:0]   shift_bytes;
  logic          shift_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= 8'h00;
      arg_buf_reg <= 32'h0;
      arg_cnt_reg <= 3'd0;
      tmo_cnt_reg <= '0;
      mem_cnt_reg <= 3'd0;
      rd_data_reg <= 16'h0;
      start_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      loaded_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      arg_buf_reg <= arg_buf_next;
      arg_cnt_reg <= arg_cnt_next;
      tmo_cnt_reg <= tmo_cnt_next;
      mem_cnt_reg <= mem_cnt_next;
      rd_data_reg <= rd_data_next;
      start_reg   <= start_next;
      overrun_reg <= overrun_next;
      loaded_reg  <= loaded_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    arg_buf_next = arg_buf_reg;
    arg_cnt_next = arg_cnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    mem_cnt_next = mem_cnt_reg;
    rd_data_next = rd_data_reg;
    start_next   = 1'b0;
    overrun_next = overrun_reg;
    loaded_next  = loaded_reg;
    shift_load   = 1'b0;
    shift_len    = LEN_ACK;
    shift_bytes  = {BYTE_ACK, 40'h0};
    case (state_reg)
      IDLE: begin
        if (rxValid) begin
          op_next      = rxData;
          arg_buf_next = 32'h0;
          arg_cnt_next = 3'd0;
          tmo_cnt_next = '0;
          loaded_next  = 1'b0;
          if (args_needed(rxData) != 3'd0) begin
            state_next = ARGS;
          end else begin
            state_next = RESP;
            start_next = (rxData == OP_START);
          end
        end
      end
      ARGS: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (rxValid) begin
          arg_buf_next = {arg_buf_reg[23:0], rxData};
          arg_cnt_next = arg_cnt_reg + 3'd1;
          tmo_cnt_next = '0;
          if (arg_cnt_reg + 3'd1 == args_needed(op_reg)) begin
            state_next   = MEM;
            mem_cnt_next = 3'd0;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      MEM: begin
        if (rxValid) overrun_next = 1'b1;
        if (mem_cnt_reg == MEM_LAST) begin
          rd_data_next = memDataOut;
          loaded_next  = 1'b0;
          state_next   = RESP;
        end else begin
          mem_cnt_next = mem_cnt_reg + 3'd1;
        end
      end
      RESP: begin
        // Covers the whole transmission; the shifter owns the TX handshake.
        if (rxValid) overrun_next = 1'b1;
        if (!loaded_reg) begin
          shift_load  = 1'b1;
          loaded_next = 1'b1;
          if (op_reg == OP_READ) begin
            shift_len   = LEN_READ;
            shift_bytes = {rd_data_reg, 32'h0};
          end else if (op_reg == OP_DUMP) begin
            shift_len   = LEN_DUMP;
            shift_bytes = {dbgPc, dbgAcc, dbgIr};
          end else if (op_reg != OP_WRITE && op_reg != OP_START) begin
            shift_bytes = {BYTE_NAK, 40'h0};
          end
        end
        if (shift_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  uart_resp_shifter u_resp_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift_load),
    .len       (shift_len),
    .resp_data (shift_bytes),
    .txValid   (txValid),
    .txData    (txData),
    .txBusy    (txBusy),
    .done      (shift_done)
  );

  assign memControl = (state_reg == MEM);
  assign memRnW     = memControl && (op_reg == OP_READ);
  assign memAddr    = !memControl ? 16'h0 :
                      (op_reg == OP_READ) ? arg_buf_reg[15:0] : arg_buf_reg[31:16];
  assign memDataIn  = (memControl && op_reg == OP_WRITE) ? arg_buf_reg[15:0] : 16'h0;
  assign start      = start_reg;
  assign rxOverrun  = overrun_reg;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench for uart_cmd_engine: memory, TX transmitter and monitors are
// modelled here; each task drives one scenario and checks hand-computed results.
module tb_uart_cmd_engine;

  logic        clk;
  logic        rst_n;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        txValid;
  logic [7:0]  txData;
  logic        txBusy;
  logic        memControl;
  logic        memRnW;
  logic [15:0] memAddr;
  logic [15:0] memDataIn;
  logic [15:0] memDataOut;
  logic        start;
  logic [15:0] dbgPc;
  logic [15:0] dbgAcc;
  logic [15:0] dbgIr;
  logic        rxOverrun;

  int n_checks = 0;
  int n_errors = 0;
  int hold_err = 0;
  int mc_cycles = 0;
  int start_cycles = 0;
  logic [15:0] mon_addr;
  logic [15:0] mon_data;
  logic        mon_rnw;
  logic [7:0]  tx_q [$];
  logic [15:0] mem_model [256];

  uart_cmd_engine #(.TIMEOUT_CYCLES(100), .MEM_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxValid    (rxValid),
    .rxData     (rxData),
    .txValid    (txValid),
    .txData     (txData),
    .txBusy     (txBusy),
    .memControl (memControl),
    .memRnW     (memRnW),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut),
    .start      (start),
    .dbgPc      (dbgPc),
    .dbgAcc     (dbgAcc),
    .dbgIr      (dbgIr),
    .rxOverrun  (rxOverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (memControl && !memRnW) mem_model[memAddr[7:0]] <= memDataIn;
    memDataOut <= mem_model[memAddr[7:0]];
  end

  // Transmitter: picks up txValid after a few cycles, then stays busy for 8.
  initial begin : tx_model
    logic [7:0] d;
    txBusy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && txValid) begin
        d = txData;
        repeat (3) begin
          @(posedge clk); #1;
          if (!txValid || txData !== d) hold_err++;
        end
        txBusy = 1'b1;
        tx_q.push_back(d);
        repeat (8) @(posedge clk);
        #1 txBusy = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (memControl) begin
        mc_cycles++;
        mon_addr = memAddr;
        mon_data = memDataIn;
        mon_rnw  = memRnW;
      end
      if (start) start_cycles++;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rxValid = 1'b1;
    rxData  = b;
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    mc_cycles    = 0;
    start_cycles = 0;
    hold_err     = 0;
  endtask

  // Bounded wait for n transmitted bytes, then let the engine settle to IDLE.
  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxValid = 1'b0; rxData = 8'h00;
    dbgPc = 16'h0; dbgAcc = 16'h0; dbgIr = 16'h0;
    @(negedge clk);
    n_checks++;
    if ({txValid, memControl, memRnW, start, rxOverrun} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b, required 00000", {txValid, memControl, memRnW, start, rxOverrun});
    end
    n_checks++;
    if (txData !== 8'h00) begin
      n_errors++; $display("FAIL reset_txdata: got %h, required 00", txData);
    end
    n_checks++;
    if ({memAddr, memDataIn} !== 32'h0) begin
      n_errors++; $display("FAIL reset_mem: got %h, required 00000000", {memAddr, memDataIn});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({txValid, memControl, start, rxOverrun} !== 4'b0) begin
      n_errors++; $display("FAIL post_reset_idle: got %b, required 0000", {txValid, memControl, start, rxOverrun});
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_write();
    logic [7:0] frame [5] = '{8'h57, 8'h00, 8'h10, 8'hBE, 8'hEF};
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    wait_tx(1);
    n_checks++;
    if (mc_cycles !== 2) begin n_errors++; $display("FAIL write_mc_cycles: got %0d, required 2", mc_cycles); end
    n_checks++;
    if (mon_rnw !== 1'b0) begin n_errors++; $display("FAIL write_rnw: got %b, required 0", mon_rnw); end
    n_checks++;
    if (mon_addr !== 16'h0010) begin n_errors++; $display("FAIL write_addr: got %h, required 0010", mon_addr); end
    n_checks++;
    if (mon_data !== 16'hBEEF) begin n_errors++; $display("FAIL write_data: got %h, required beef", mon_data); end
    n_checks++;
    if (tx_q.size() !== 1) begin n_errors++; $display("FAIL write_tx_len: got %0d, required 1", tx_q.size()); end
    n_checks++;
    if (tx_q[0] !== 8'h06) begin n_errors++; $display("FAIL write_ack: got %h, required 06", tx_q[0]); end
    n_checks++;
    if (hold_err !== 0) begin n_errors++; $display("FAIL write_hold: got %0d violations, required 0", hold_err); end
    $display("write: addr=%h data=%h reply=%h", mon_addr, mon_data, tx_q[0]);
  endtask

  task automatic test_read();
    logic [7:0] frame [3] = '{8'h52, 8'h00, 8'h10};
    clear_mon();
    for (int i = 0; i < 3; i++) send_byte(frame[i]);
    wait_tx(2);
    n_checks++;
    if (mc_cycles !== 2) begin n_errors++; $display("FAIL read_mc_cycles: got %0d, required 2", mc_cycles); end
    n_checks++;
    if (mon_rnw !== 1'b1) begin n_errors++; $display("FAIL read_rnw: got %b, required 1", mon_rnw); end
    n_checks++;
    if (mon_addr !== 16'h0010) begin n_errors++; $display("FAIL read_addr: got %h, required 0010", mon_addr); end
    n_checks++;
    if (tx_q.size() !== 2) begin n_errors++; $display("FAIL read_tx_len: got %0d, required 2", tx_q.size()); end
    n_checks++;
    if ({tx_q[0], tx_q[1]} !== 16'hBEEF) begin
      n_errors++; $display("FAIL read_data: got %h%h, required beef", tx_q[0], tx_q[1]);
    end
    $display("read: addr=%h reply=%h %h", mon_addr, tx_q[0], tx_q[1]);
  endtask

  task automatic test_start();
    clear_mon();
    send_byte(8'h53);
    wait_tx(1);
    n_checks++;
    if (start_cycles !== 1) begin n_errors++; $display("FAIL start_pulse: got %0d cycles, required 1", start_cycles); end
    n_checks++;
    if (tx_q.size() !== 1) begin n_errors++; $display("FAIL start_tx_len: got %0d, required 1", tx_q.size()); end
    n_checks++;
    if (tx_q[0] !== 8'h06) begin n_errors++; $display("FAIL start_ack: got %h, required 06", tx_q[0]); end
    repeat (50) @(posedge clk);
    n_checks++;
    if (start_cycles !== 1) begin n_errors++; $display("FAIL start_again: got %0d cycles, required 1", start_cycles); end
    $display("start: pulses=%0d reply=%h", start_cycles, tx_q[0]);
  endtask

  task automatic test_dump();
    logic [7:0] exp [6] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    dbgPc = 16'h0123; dbgAcc = 16'h4567; dbgIr = 16'h89AB;
    clear_mon();
    send_byte(8'h44);
    wait_tx(6);
    n_checks++;
    if (tx_q.size() !== 6) begin n_errors++; $display("FAIL dump_tx_len: got %0d, required 6", tx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (tx_q[i] !== exp[i]) begin
        n_errors++; $display("FAIL dump_byte%0d: got %h, required %h", i, tx_q[i], exp[i]);
      end
    end
    n_checks++;
    if (hold_err !== 0) begin n_errors++; $display("FAIL dump_hold: got %0d violations, required 0", hold_err); end
    $display("dump: %0d bytes, first=%h last=%h", tx_q.size(), tx_q[0], tx_q[5]);
  endtask

  task automatic test_overrun();
    n_checks++;
    if (rxOverrun !== 1'b0) begin n_errors++; $display("FAIL overrun_pre: got %b, required 0", rxOverrun); end
    clear_mon();
    send_byte(8'h7F);
    repeat (5) @(posedge clk);
    send_byte(8'h53);
    wait_tx(1);
    repeat (30) @(posedge clk);
    n_checks++;
    if (tx_q.size() !== 1) begin n_errors++; $display("FAIL nak_tx_len: got %0d, required 1", tx_q.size()); end
    n_checks++;
    if (tx_q[0] !== 8'h15) begin n_errors++; $display("FAIL nak_byte: got %h, required 15", tx_q[0]); end
    n_checks++;
    if (rxOverrun !== 1'b1) begin n_errors++; $display("FAIL overrun_flag: got %b, required 1", rxOverrun); end
    n_checks++;
    if (start_cycles !== 0) begin n_errors++; $display("FAIL overrun_dropped: got %0d start cycles, required 0", start_cycles); end
    $display("unknown+overrun: reply=%h overrun=%b", tx_q[0], rxOverrun);
  endtask

  task automatic test_timeout();
    clear_mon();
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (110) @(posedge clk);
    n_checks++;
    if (mc_cycles !== 0) begin n_errors++; $display("FAIL timeout_mem: got %0d cycles, required 0", mc_cycles); end
    n_checks++;
    if (tx_q.size() !== 0) begin n_errors++; $display("FAIL timeout_tx: got %0d bytes, required 0", tx_q.size()); end
    send_byte(8'h53);
    wait_tx(1);
    n_checks++;
    if (tx_q.size() !== 1 || tx_q[0] !== 8'h06) begin
      n_errors++; $display("FAIL timeout_recover: got %0d bytes first=%h, required 1 byte 06", tx_q.size(), tx_q[0]);
    end
    $display("timeout: partial frame discarded, recovery reply=%h", tx_q[0]);
  endtask

  // Next byte lands exactly on the cycle the timeout would expire.
  task automatic test_timeout_edge();
    clear_mon();
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (98) @(posedge clk);
    send_byte(8'h30);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_tx(1);
    n_checks++;
    if (mc_cycles !== 2) begin n_errors++; $display("FAIL edge_mc_cycles: got %0d, required 2", mc_cycles); end
    n_checks++;
    if ({mon_addr, mon_data} !== 32'h0030_1234) begin
      n_errors++; $display("FAIL edge_access: got %h/%h, required 0030/1234", mon_addr, mon_data);
    end
    n_checks++;
    if (tx_q[0] !== 8'h06) begin n_errors++; $display("FAIL edge_ack: got %h, required 06", tx_q[0]); end
    $display("timeout edge: addr=%h data=%h reply=%h", mon_addr, mon_data, tx_q[0]);
  endtask

  task automatic test_reset_mid();
    logic [7:0] frame [5] = '{8'h57, 8'h00, 8'h20, 8'h12, 8'h34};
    int k = 0;
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    while (!memControl && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (memControl !== 1'b1) begin n_errors++; $display("FAIL midreset_mem_phase: got %b, required 1", memControl); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({memControl, txValid, start} !== 3'b000) begin
      n_errors++; $display("FAIL midreset_async: got %b, required 000", {memControl, txValid, start});
    end
    n_checks++;
    if (rxOverrun !== 1'b0) begin n_errors++; $display("FAIL midreset_overrun: got %b, required 0", rxOverrun); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (100) @(posedge clk);
    n_checks++;
    if (tx_q.size() !== 0) begin n_errors++; $display("FAIL midreset_tx: got %0d bytes, required 0", tx_q.size()); end
    n_checks++;
    if (mc_cycles !== 0) begin n_errors++; $display("FAIL midreset_mem: got %0d cycles, required 0", mc_cycles); end
    $display("reset mid-frame: tx=%0d mem cycles=%0d", tx_q.size(), mc_cycles);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_start();
    test_dump();
    test_overrun();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
